// File: rtl/true_dpr_bwe.sv
// True dual-port RAM with per-byte write enables, selectable read-during-write mode,
// optional output register, cross-port collision flag and a post-reset clear engine.
module true_dpr_bwe #(
    parameter int unsigned ADDR_SIZE      = 8,
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned BYTE_SIZE      = 8,
    parameter int unsigned RD_MODE        = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned NUM_BYTES     = DATA_SIZE / BYTE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_a,
    input  logic [NUM_BYTES-1:0] we_a,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [DATA_SIZE-1:0] din_a,
    output logic [DATA_SIZE-1:0] dout_a,
    output logic                 valid_a,
    input  logic                 en_b,
    input  logic [NUM_BYTES-1:0] we_b,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [DATA_SIZE-1:0] din_b,
    output logic [DATA_SIZE-1:0] dout_b,
    output logic                 valid_b,
    output logic                 collision,
    output logic                 init_busy
);

    localparam int unsigned RAM_SIZE = 1 << ADDR_SIZE;

    if ((DATA_SIZE % BYTE_SIZE) != 0 || RD_MODE > 2) begin : g_param_check
        $error("true_dpr_bwe: illegal DATA_SIZE/BYTE_SIZE or RD_MODE");
    end

    typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

    clr_state_e           state_q;
    logic [ADDR_SIZE-1:0] ptr_q;
    logic                 init_busy_q;
    logic [DATA_SIZE-1:0] mem [RAM_SIZE];

    logic                 acc_a, acc_b, wr_a, wr_b;
    logic [DATA_SIZE-1:0] old_a, old_b, merged_a, merged_b;
    logic [DATA_SIZE-1:0] rd_a_q, rd_b_q, rd_a_d, rd_b_d;
    logic                 vld_a_q, vld_b_q, vld_a_d, vld_b_d;
    logic                 coll_q;

    // Port requests are dropped entirely while the clear engine owns the array.
    assign acc_a = en_a & ~init_busy_q;
    assign acc_b = en_b & ~init_busy_q;
    assign wr_a  = acc_a & (we_a != '0);
    assign wr_b  = acc_b & (we_b != '0);
    assign old_a = mem[addr_a];
    assign old_b = mem[addr_b];

    // Own-port merge only: the writer never sees the other port's bytes.
    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (we_a[i]) merged_a[i*BYTE_SIZE +: BYTE_SIZE] = din_a[i*BYTE_SIZE +: BYTE_SIZE];
            if (we_b[i]) merged_b[i*BYTE_SIZE +: BYTE_SIZE] = din_b[i*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    function automatic logic [DATA_SIZE:0] stage1_next(input logic acc, input logic wr,
                                                       input logic [DATA_SIZE-1:0] old_w,
                                                       input logic [DATA_SIZE-1:0] merged_w,
                                                       input logic [DATA_SIZE-1:0] cur_w);
        if (!acc) return {1'b0, cur_w};
        if (!wr) return {1'b1, old_w};
        if (RD_MODE == 0) return {1'b1, old_w};
        if (RD_MODE == 1) return {1'b1, merged_w};
        return {1'b0, cur_w};
    endfunction

    always_comb begin
        {vld_a_d, rd_a_d} = stage1_next(acc_a, wr_a, old_a, merged_a, rd_a_q);
        {vld_b_d, rd_b_d} = stage1_next(acc_b, wr_b, old_b, merged_b, rd_b_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            ptr_q       <= '0;
            init_busy_q <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                StClear: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (&ptr_q) state_q <= StIdle;
                end
                default: init_busy_q <= 1'b0;
            endcase
        end
    end

    // Port B is written after port A so it wins shared bytes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == StClear) mem[ptr_q] <= '0;
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_a && we_a[i]) mem[addr_a][i*BYTE_SIZE +: BYTE_SIZE] <= din_a[i*BYTE_SIZE +: BYTE_SIZE];
            end
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_b && we_b[i]) mem[addr_b][i*BYTE_SIZE +: BYTE_SIZE] <= din_b[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
            coll_q  <= acc_a & acc_b & (addr_a == addr_b) & (wr_a | wr_b);
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_SIZE-1:0] rd_a_q2, rd_b_q2;
        logic                 vld_a_q2, vld_b_q2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_a_q2  <= '0;
                rd_b_q2  <= '0;
                vld_a_q2 <= 1'b0;
                vld_b_q2 <= 1'b0;
            end else begin
                rd_a_q2  <= rd_a_q;
                rd_b_q2  <= rd_b_q;
                vld_a_q2 <= vld_a_q;
                vld_b_q2 <= vld_b_q;
            end
        end

        assign dout_a  = rd_a_q2;
        assign dout_b  = rd_b_q2;
        assign valid_a = vld_a_q2;
        assign valid_b = vld_b_q2;
    end else begin : g_no_out_reg
        assign dout_a  = rd_a_q;
        assign dout_b  = rd_b_q;
        assign valid_a = vld_a_q;
        assign valid_b = vld_b_q;
    end

    assign collision = coll_q;
    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_true_dpr_bwe.sv
// Bench for true_dpr_bwe: three instances (RF/no reg, WF/out reg, NC/no reg) share stimulus
// and are checked every cycle against a word-array reference model.
module tb_true_dpr_bwe;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0, addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;

    logic [31:0] dout_a_w [NI];
    logic [31:0] dout_b_w [NI];
    logic        valid_a_w [NI];
    logic        valid_b_w [NI];
    logic        coll_w [NI];
    logic        busy_w [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        true_dpr_bwe #(
            .ADDR_SIZE     (4),
            .DATA_SIZE     (32),
            .BYTE_SIZE     (8),
            .RD_MODE       (g),
            .OUT_REG       ((g == 1) ? 1 : 0),
            .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_a     (en_a),
            .we_a     (we_a),
            .addr_a   (addr_a),
            .din_a    (din_a),
            .dout_a   (dout_a_w[g]),
            .valid_a  (valid_a_w[g]),
            .en_b     (en_b),
            .we_b     (we_b),
            .addr_b   (addr_b),
            .din_b    (din_b),
            .dout_b   (dout_b_w[g]),
            .valid_b  (valid_b_w[g]),
            .collision(coll_w[g]),
            .init_busy(busy_w[g])
        );
    end

    // Reference model: plain word array plus per-instance delivered-data history.
    logic [31:0] ref_mem [16];
    logic        m_busy;
    int          m_cnt;
    logic        m_col;
    logic [31:0] s1d [NI][2];
    logic [31:0] s2d [NI][2];
    logic        s1v [NI][2];
    logic        s2v [NI][2];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ea;
        logic [3:0]  wa;
        logic [3:0]  aa;
        logic [31:0] da;
        logic        eb;
        logic [3:0]  wb;
        logic [3:0]  ab;
        logic [31:0] db;
        logic [31:0] xda;
        logic        xva;
        logic [31:0] xdb;
        logic        xvb;
        logic        xcol;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic        pe [2];
        logic [3:0]  pw [2];
        logic [3:0]  pa [2];
        logic [31:0] pd [2];
        logic [31:0] old [2];
        logic [31:0] mrg;
        pe[0] = en_a; pw[0] = we_a; pa[0] = addr_a; pd[0] = din_a;
        pe[1] = en_b; pw[1] = we_b; pa[1] = addr_b; pd[1] = din_b;
        if (!rst_n) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_col  = 1'b0;
            for (int k = 0; k < NI; k++)
                for (int p = 0; p < 2; p++) begin
                    s1d[k][p] = '0; s1v[k][p] = 1'b0; s2d[k][p] = '0; s2v[k][p] = 1'b0;
                end
        end else begin
            for (int k = 0; k < NI; k++)
                for (int p = 0; p < 2; p++) begin
                    s2d[k][p] = s1d[k][p];
                    s2v[k][p] = s1v[k][p];
                end
            for (int p = 0; p < 2; p++) old[p] = ref_mem[pa[p]];
            if (m_busy) begin
                m_col = 1'b0;
                for (int k = 0; k < NI; k++)
                    for (int p = 0; p < 2; p++) s1v[k][p] = 1'b0;
                if (m_cnt < 16) begin
                    ref_mem[m_cnt] = '0;
                    m_cnt++;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_col = pe[0] && pe[1] && (pa[0] == pa[1]) && (pw[0] != 0 || pw[1] != 0);
                for (int p = 0; p < 2; p++) begin
                    mrg = old[p];
                    for (int i = 0; i < 4; i++) if (pw[p][i]) mrg[8*i +: 8] = pd[p][8*i +: 8];
                    for (int k = 0; k < NI; k++) begin
                        if (!pe[p]) s1v[k][p] = 1'b0;
                        else if (pw[p] == 0 || k == 0) begin s1d[k][p] = old[p]; s1v[k][p] = 1'b1; end
                        else if (k == 1) begin s1d[k][p] = mrg; s1v[k][p] = 1'b1; end
                        else s1v[k][p] = 1'b0;
                    end
                end
                for (int p = 0; p < 2; p++)
                    for (int i = 0; i < 4; i++)
                        if (pe[p] && pw[p][i]) ref_mem[pa[p]][8*i +: 8] = pd[p][8*i +: 8];
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            if (k == 1) begin
                chk($sformatf("dut%0d dout_a", k), dout_a_w[k], s2d[k][0]);
                chk($sformatf("dut%0d valid_a", k), 32'(valid_a_w[k]), 32'(s2v[k][0]));
                chk($sformatf("dut%0d dout_b", k), dout_b_w[k], s2d[k][1]);
                chk($sformatf("dut%0d valid_b", k), 32'(valid_b_w[k]), 32'(s2v[k][1]));
            end else begin
                chk($sformatf("dut%0d dout_a", k), dout_a_w[k], s1d[k][0]);
                chk($sformatf("dut%0d valid_a", k), 32'(valid_a_w[k]), 32'(s1v[k][0]));
                chk($sformatf("dut%0d dout_b", k), dout_b_w[k], s1d[k][1]);
                chk($sformatf("dut%0d valid_b", k), 32'(valid_b_w[k]), 32'(s1v[k][1]));
            end
            chk($sformatf("dut%0d collision", k), 32'(coll_w[k]), 32'(m_col));
            chk($sformatf("dut%0d init_busy", k), 32'(busy_w[k]), 32'(m_busy));
        end
    endtask

    task automatic step(input logic r, input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                        input logic [31:0] da, input logic eb, input logic [3:0] wb,
                        input logic [3:0] ab, input logic [31:0] db);
        rst_n = r; en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [3:0] ra;

        tbl[0] = '{1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0,
                   32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0,
                   32'hAABBCCDD, 1'b1, 32'h00000000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0,
                   32'hAABBCCDD, 1'b0, 32'hAA22CC44, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'hF, 4'd3, 32'h12345678, 1'b0, 4'h0, 4'd0, 32'h0,
                   32'h00000000, 1'b1, 32'hAA22CC44, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 4'hF, 4'd7, 32'hFFFFFFFF, 1'b1, 4'h3, 4'd7, 32'h00000000,
                   32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0,
                   32'h00000000, 1'b0, 32'hFFFF0000, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b0, 4'h0, 4'd0, 32'h0,
                   32'h00000000, 1'b1, 32'hFFFF0000, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 4'hF, 4'd9, 32'hDEADBEEF, 1'b1, 4'h0, 4'd9, 32'h0,
                   32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0,
                   32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0,
                   32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};

        repeat (3) step(1'b0, 1'b1, 4'hF, 4'd1, 32'h5555AAAA, 1'b0, 4'h0, 4'd0, 32'h0);
        chk("reset init_busy", 32'(busy_w[0]), 32'd1);
        chk("reset dout_a", dout_a_w[0], 32'h0);

        // Clear after release: port A keeps reading while the engine runs.
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
            if (n == 0) chk("read during clear valid_a", 32'(valid_a_w[0]), 32'd0);
            if (busy_w[0]) cnt++;
            else break;
        end
        chk("clear busy cycles", cnt, 32'd16);

        for (int a = 0; a < 16; a++) begin
            step(1'b1, 1'b1, 4'h0, 4'(a), 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
            chk($sformatf("cleared word %0d", a), dout_a_w[0], 32'h0);
            chk($sformatf("cleared valid %0d", a), 32'(valid_a_w[0]), 32'd1);
        end

        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da,
                 tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
            chk($sformatf("vec%0d dout_a", i), dout_a_w[0], tbl[i].xda);
            chk($sformatf("vec%0d valid_a", i), 32'(valid_a_w[0]), 32'(tbl[i].xva));
            chk($sformatf("vec%0d dout_b", i), dout_b_w[0], tbl[i].xdb);
            chk($sformatf("vec%0d valid_b", i), 32'(valid_b_w[0]), 32'(tbl[i].xvb));
            chk($sformatf("vec%0d collision", i), 32'(coll_w[0]), 32'(tbl[i].xcol));
        end

        // Random traffic, biased towards shared addresses and occasional reset.
        for (int n = 0; n < 600; n++) begin
            ra = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 149) != 0),
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                 ra, $urandom(),
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 0) ? ra : 4'($urandom_range(0, 15)),
                 $urandom());
        end

        // Reset in the middle of a clear restarts the full sweep.
        step(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        repeat (8) step(1'b1, 1'b1, 4'h0, 4'd4, 32'h0, 1'b1, 4'h0, 4'd4, 32'h0);
        step(1'b0, 1'b1, 4'h0, 4'd4, 32'h0, 1'b1, 4'h0, 4'd4, 32'h0);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 4'h0, 4'd4, 32'h0, 1'b1, 4'h0, 4'd4, 32'h0);
            if (busy_w[0]) cnt++;
            else break;
        end
        chk("restarted clear busy cycles", cnt, 32'd16);
        repeat (3) begin
            step(1'b1, 1'b1, 4'h0, 4'd4, 32'h0, 1'b1, 4'h0, 4'd4, 32'h0);
            chk("dual read no collision", 32'(coll_w[0]), 32'd0);
            chk("dual read data", dout_b_w[0], 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/true_dpr_bwe.md
Name: true_dpr_bwe

Overview:
Parametrised next-generation true dual-port RAM: two fully independent read/write ports on one clock, with per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, cross-port collision detection and a post-reset memory clear engine. Drop-in storage primitive for packet buffers and register files; it supersedes the plain 8x8 dual-port RAM.

Parameters:
ADDR_SIZE, 8, address width; RAM_SIZE = 1 << ADDR_SIZE words (derived, not overridable).
DATA_SIZE, 32, word width; must be a multiple of BYTE_SIZE.
BYTE_SIZE, 8, bits per write-enable lane; NUM_BYTES = DATA_SIZE / BYTE_SIZE (derived).
RD_MODE, 0, same-port read-during-write: 0 = read-first, 1 = write-first, 2 = no-change.
OUT_REG, 0, 1 adds a second output register stage (read latency 2 instead of 1).
CLEAR_ON_RESET, 1, 1 zeroes every word after reset release; 0 leaves contents untouched.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
en_a  in  1  port A access enable
we_a  in  NUM_BYTES  port A byte write enables (all 0 = read)
addr_a  in  ADDR_SIZE  port A word address
din_a  in  DATA_SIZE  port A write data
dout_a  out  DATA_SIZE  port A read data
valid_a  out  1  dout_a carries new data this cycle
en_b, we_b, addr_b, din_b, dout_b, valid_b: same as port A, for port B
collision  out  1  same-address conflict pulse
init_busy  out  1  clear engine active; port requests ignored

Behaviour:
- Reset (rst_n low at a clk edge): dout_a = dout_b = 0, all pipeline stages = 0, valid_a = valid_b = 0, collision = 0, clear pointer = 0.
- Reset, init_busy: forced to 1 if CLEAR_ON_RESET = 1, else 0. Memory array is not written while rst_n is low.
- Clear FSM, states IDLE and CLEAR:
  - First edge with rst_n high enters CLEAR if CLEAR_ON_RESET = 1.
  - In CLEAR, writes 0 to mem[ptr] each cycle, ptr running 0 to RAM_SIZE-1 (exactly RAM_SIZE cycles).
  - After the write to RAM_SIZE-1: state goes to IDLE, init_busy drops on the following edge.
  - Reset during CLEAR restarts from ptr 0.
  - While init_busy = 1: en_a/en_b are ignored (no writes, valid stays 0, dout holds, collision stays 0).
- Write: on an edge with en_x = 1 and we_x[i] = 1, mem[addr_x] byte i <= din_x byte i. Bytes with we_x[i] = 0 are unchanged.
- Read latency, OUT_REG = 0: stage-1 register updates on the access edge; dout_x and valid_x are visible in the cycle after the access.
- Read latency, OUT_REG = 1: stage 2 copies stage 1 (data and valid) every cycle; dout_x and valid_x appear 2 cycles after the access.
- Same-port read-during-write (en_x = 1, we_x != 0):
  - RF: stage 1 gets the old word; valid = 1.
  - WF: stage 1 gets the merged new word; valid = 1.
  - NC: stage 1 holds its value; valid = 0.
- Pure read (we_x = 0): stage 1 gets mem[addr_x]; valid = 1.
- en_x = 0: stage-1 data holds; valid = 0.
- Collision condition: en_a & en_b & (addr_a == addr_b) & (we_a != 0 | we_b != 0). Not a collision if both ports are reads.
  - collision = 1 in the cycle after the conflicting edge, for one cycle per conflicting edge. Not delayed by OUT_REG.
  - Write-write, per byte: if both enable byte i, port B's byte wins. A byte written by only one port takes that port's data.
  - Cross-port read (one port reads, the other writes the same address): the reader gets the old word, regardless of RD_MODE. The writer's own readback follows RD_MODE but excludes the other port's bytes.
- Addresses wrap naturally; there is no out-of-range case.
- Elaboration must fail if DATA_SIZE % BYTE_SIZE != 0 or RD_MODE > 2.

Test Plan:
- Clear, CLEAR_ON_RESET = 1, ADDR_SIZE = 4: hold rst_n low 3 cycles, then release -> init_busy high exactly 16 cycles after release. A port A read issued during the clear gives valid_a = 0. Reading every address afterwards returns 0x00000000.
- Byte writes: port A writes 0xAABBCCDD to addr 5 with we_a = 4'b1111, then 0x11223344 with we_a = 4'b0101 -> port B read of addr 5 returns 0xAA22CC44, one cycle after the read (OUT_REG = 0) or two cycles (OUT_REG = 1).
- Read-during-write, mem[3] = 0x0, port A writes 0x12345678 to addr 3 -> dout_a is 0x00000000 with valid (RF), 0x12345678 with valid (WF), or the previous dout with valid_a = 0 (NC).
- Write-write collision, same edge, addr 7: A writes 0xFFFFFFFF with we_a = 1111, B writes 0x00000000 with we_b = 0011 -> collision pulses 1 cycle; mem[7] = 0xFFFF0000.
- Cross-port read: mem[9] = 0xCAFEF00D; A writes 0xDEADBEEF to addr 9 while B reads addr 9 -> dout_b = 0xCAFEF00D and collision = 1. The next B read returns 0xDEADBEEF.
- Reset mid-clear (ADDR_SIZE = 4): pull rst_n low at ptr = 8 for 1 cycle -> clear restarts, init_busy stays high a further 16 cycles; dual reads of the same address raise no collision.
